// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: round-robin byte arbitration over N_REQ requesters, CSR bus master for the UART.
// Optional feature macro: UART_TXSEQ_STATS_EN adds the tx_count output (bytes confirmed sent).
module uart_tx_sequencer #(
    parameter int         N_REQ    = 4,
    parameter logic [3:0] BR_SEL   = 4'hF,
    parameter logic [7:0] CLK_MHZ  = 8'd50,
    parameter int         START_TO = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   ack,
    output logic               busy,
    output logic               start_err,
`ifdef UART_TXSEQ_STATS_EN
    output logic [15:0]        tx_count,
`endif
    output logic [31:0]        waddr,
    output logic [31:0]        wdata,
    output logic               wen,
    output logic [3:0]         wstrb,
    input  logic               wready,
    output logic [31:0]        raddr,
    output logic               ren,
    input  logic [31:0]        rdata
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (START_TO > 1) ? $clog2(START_TO) : 1;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_WDATA, S_START, S_CLEAR, S_RD, S_CHK
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         byte_q, byte_d;
    logic               seen_q, seen_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               wen_q, wen_d;
    logic               ren_q, ren_d;
    logic [15:0]        txc_q, txc_d;
    logic               gnt_found;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   gnt_nxt;
    int                 idx;
    logic               wr_done;
    logic               unused_rdata;

    function automatic logic [31:0] ctrl_word(input logic strtx);
        return {16'h0, CLK_MHZ, BR_SEL, 2'b00, strtx, 1'b1};
    endfunction

    assign wr_done      = wen_q & wready;
    assign unused_rdata = ^rdata[31:1];

    // First pending requester at or after the round-robin pointer.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!gnt_found && req[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(idx);
            end
        end
        gnt_nxt = (int'(gnt_idx) == N_REQ - 1) ? '0 : PTR_W'(int'(gnt_idx) + 1);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        byte_d  = byte_q;
        seen_d  = seen_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        txc_d   = txc_q;
        ack     = '0;
        case (state_q)
            S_INIT:  if (wr_done) state_d = S_IDLE;
            S_IDLE: begin
                if (gnt_found) begin
                    ack[gnt_idx] = 1'b1;
                    byte_d       = req_data[8*int'(gnt_idx) +: 8];
                    ptr_d        = gnt_nxt;
                    seen_d       = 1'b0;
                    cnt_d        = '0;
                    state_d      = S_WDATA;
                end
            end
            S_WDATA: if (wr_done) state_d = S_START;
            S_START: if (wr_done) state_d = S_CLEAR;
            S_CLEAR: if (wr_done) state_d = S_RD;
            S_RD:    state_d = S_CHK;
            S_CHK: begin
                if (rdata[0]) begin
                    seen_d  = 1'b1;
                    state_d = S_RD;
                end else if (seen_q) begin
                    txc_d   = txc_q + 16'd1;
                    state_d = S_IDLE;
                end else if (cnt_q < CNT_W'(START_TO - 1)) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_RD;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_INIT;
        endcase
        // Bus strobes are registered from the next state so reset forces them low.
        wen_d  = (state_d == S_INIT) || (state_d == S_WDATA) ||
                 (state_d == S_START) || (state_d == S_CLEAR);
        ren_d  = (state_d == S_RD);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
            byte_q  <= '0;
            seen_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            txc_q   <= '0;
            busy_q  <= 1'b0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            byte_q  <= byte_d;
            seen_q  <= seen_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            txc_q   <= txc_d;
            busy_q  <= busy_d;
            wen_q   <= wen_d;
            ren_q   <= ren_d;
        end
    end

    always_comb begin
        waddr = '0;
        wdata = '0;
        wstrb = '0;
        if (wen_q) begin
            case (state_q)
                S_WDATA: begin
                    waddr = 32'h8;
                    wdata = {24'h0, byte_q};
                    wstrb = 4'b0001;
                end
                S_START: begin
                    wdata = ctrl_word(1'b1);
                    wstrb = 4'b0011;
                end
                default: begin
                    wdata = ctrl_word(1'b0);
                    wstrb = 4'b0011;
                end
            endcase
        end
    end

    assign wen       = wen_q;
    assign ren       = ren_q;
    assign raddr     = ren_q ? 32'h4 : 32'h0;
    assign busy      = busy_q;
    assign start_err = err_q;
`ifdef UART_TXSEQ_STATS_EN
    assign tx_count  = txc_q;
`else
    logic unused_txc;
    assign unused_txc = ^txc_q;
`endif

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: table of arbitration frames plus wait-state, stuck-TBUSY and async-reset sequences.
module tb_uart_tx_sequencer;
    localparam int N_REQ    = 4;
    localparam int START_TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  ack;
    logic        busy, start_err;
    logic [31:0] waddr, wdata, raddr;
    logic        wen, ren;
    logic [3:0]  wstrb;
    logic        wready = 1'b1;
    logic [31:0] rdata = '0;
`ifdef UART_TXSEQ_STATS_EN
    logic [15:0] tx_count;
`endif

    always #5 clk = ~clk;

    uart_tx_sequencer #(.N_REQ(N_REQ), .BR_SEL(4'hF), .CLK_MHZ(8'd50), .START_TO(START_TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .busy(busy), .start_err(start_err),
`ifdef UART_TXSEQ_STATS_EN
        .tx_count(tx_count),
`endif
        .waddr(waddr), .wdata(wdata), .wen(wen), .wstrb(wstrb), .wready(wready),
        .raddr(raddr), .ren(ren), .rdata(rdata)
    );

    // UART register block model: TBUSY high for tb_len cycles after an STRTX=1 write.
    int          tb_len = 0;
    int          tbusy_cnt = 0;
    int          ack_cnt = 0;
    int          ren_cnt = 0;
    logic [3:0]  ack_last = '0;
    logic [67:0] wlog[$];

    always @(posedge clk) begin
        if (wen && wready) wlog.push_back({waddr, wdata, wstrb});
        if (ren) begin
            rdata   <= {31'b0, (tbusy_cnt > 0)};
            ren_cnt <= ren_cnt + 1;
        end
        if (wen && wready && waddr == 32'h0 && wdata[1]) tbusy_cnt <= tb_len;
        else if (tbusy_cnt > 0) tbusy_cnt <= tbusy_cnt - 1;
        if (ack != 4'b0) begin
            ack_cnt  <= ack_cnt + 1;
            ack_last <= ack;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    localparam logic [67:0] W_INIT = {32'h0, 32'h0000_32F1, 4'b0011};
    localparam logic [67:0] W_STRT = {32'h0, 32'h0000_32F3, 4'b0011};

    task automatic init_check(input string nm);
        int base_w;
        bit ok;
        base_w = wlog.size();
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wen) begin ok = 1; break; end
        end
        chk({nm, "_wen"}, ok, 1'b1);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        chk({nm, "_idle"}, ok, 1'b1);
        chk({nm, "_wr_count"}, wlog.size() - base_w, 1);
        if (wlog.size() > base_w) chk({nm, "_wr"}, wlog[base_w], W_INIT);
    endtask

    task automatic do_frame(input string nm, input logic [3:0] r, input logic [31:0] d,
                            input logic [3:0] exp_ack, input logic [7:0] exp_byte,
                            input int blen, input int hold);
        int base_w, base_a, stable;
        bit ok;
        logic [67:0] w_data;
        w_data = {32'h8, 24'h0, exp_byte, 4'b0001};
        base_w = wlog.size();
        base_a = ack_cnt;
        tb_len = blen;
        @(negedge clk);
        wready   = (hold == 0);
        req      = r;
        req_data = d;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ack_cnt != base_a) begin ok = 1; break; end
        end
        req = '0;
        chk({nm, "_ack_seen"}, ok, 1'b1);
        chk({nm, "_ack_vec"}, ack_last, exp_ack);
        chk({nm, "_wen_after_ack"}, {wen, waddr, wdata, wstrb}, {1'b1, w_data});
        if (hold > 0) begin
            stable = 0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if ({wen, waddr, wdata, wstrb} == {1'b1, w_data} && !ren) stable++;
            end
            chk({nm, "_hold_stable"}, stable, hold);
            wready = 1'b1;
        end
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        chk({nm, "_done"}, ok, 1'b1);
        chk({nm, "_ack_once"}, ack_cnt - base_a, 1);
        chk({nm, "_wr_count"}, wlog.size() - base_w, 3);
        if (wlog.size() >= base_w + 3)
            chk({nm, "_wr_seq"}, {wlog[base_w], wlog[base_w+1], wlog[base_w+2]},
                {w_data, W_STRT, W_INIT});
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  exp_ack;
        logic [7:0]  exp_byte;
        int          blen;
    } vec_t;

    vec_t tv[9];
    int   exp_tx = 0;

    initial begin
        int  r0;
        bit  ok;
        tv[0] = '{4'b1111, 32'h4433_2211, 4'b0001, 8'h11, 3};
        tv[1] = '{4'b1111, 32'h4433_2211, 4'b0010, 8'h22, 5};
        tv[2] = '{4'b1111, 32'h4433_2211, 4'b0100, 8'h33, 3};
        tv[3] = '{4'b1111, 32'h4433_2211, 4'b1000, 8'h44, 8};
        tv[4] = '{4'b1111, 32'h8877_6655, 4'b0001, 8'h55, 2};
        tv[5] = '{4'b0010, 32'h0000_A500, 4'b0010, 8'hA5, 20};
        tv[6] = '{4'b1001, 32'hC300_003C, 4'b1000, 8'hC3, 4};
        tv[7] = '{4'b1001, 32'hC300_003C, 4'b0001, 8'h3C, 4};
        tv[8] = '{4'b0100, 32'h005A_0000, 4'b0100, 8'h5A, 6};

        repeat (2) @(negedge clk);
        chk("reset_outputs", {ack, busy, start_err, wen, waddr, wdata, wstrb, raddr, ren}, '0);
        rst = 1'b1;
        init_check("init");

        for (int i = 0; i < 9; i++) begin
            do_frame($sformatf("vec%0d", i), tv[i].req, tv[i].data, tv[i].exp_ack,
                     tv[i].exp_byte, tv[i].blen, 0);
            exp_tx++;
        end

        do_frame("wait_state", 4'b0100, 32'h00E7_0000, 4'b0100, 8'hE7, 6, 5);
        exp_tx++;
        chk("no_start_err", start_err, 1'b0);
`ifdef UART_TXSEQ_STATS_EN
        chk("tx_count", tx_count, exp_tx[15:0]);
`endif

        r0 = ren_cnt;
        do_frame("stuck", 4'b0001, 32'h0000_0077, 4'b0001, 8'h77, 0, 0);
        chk("stuck_polls", ren_cnt - r0, START_TO);
        chk("stuck_err", start_err, 1'b1);
`ifdef UART_TXSEQ_STATS_EN
        chk("tx_count_stuck", tx_count, exp_tx[15:0]);
`endif

        // Reset asserted while the FSM is issuing a status read.
        tb_len = 20;
        r0 = ack_cnt;
        @(negedge clk);
        req = 4'b0010;
        req_data = 32'h0000_A500;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack_cnt != r0) begin ok = 1; break; end
        end
        req = '0;
        chk("rd_rst_ack", ok, 1'b1);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ren) begin ok = 1; break; end
        end
        chk("rd_rst_reach_rd", ok, 1'b1);
        rst = 1'b0;
        #1;
        chk("rd_rst_outputs", {ack, busy, start_err, wen, waddr, wdata, wstrb, raddr, ren}, '0);
`ifdef UART_TXSEQ_STATS_EN
        chk("rd_rst_tx_count", tx_count, 16'h0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
        init_check("reinit");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
